// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a LOAD phase (loader writes words) and a RUN phase
// (single-cycle fetches by byte address, with fault substitution).
module instr_mem_ctrl #(
    parameter int                DATA_W   = 24,
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = 24,
    parameter logic [DATA_W-1:0] NOP_WORD = 24'b111000000000000000000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH):0]   load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_done,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_data,
    output logic                     fetch_fault,
    output logic                     ready,
    output logic                     load_err,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int LW = $clog2(DEPTH);
    localparam int AW = LW + 1;

    typedef enum logic {LOAD, RUN} state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              nop_q;

    logic              load_ok;
    logic              load_bad;
    logic              accept;
    logic [ADDR_W-3:0] idx;
    logic              misaligned;
    logic              out_of_range;
    logic              unloaded;
    logic              fault_n;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (load_done) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        ready = (state == RUN);
    end

    // Top bit of load_addr set means the index is at or beyond DEPTH.
    assign load_ok  = (state == LOAD) && load_we && !load_addr[AW-1];
    assign load_bad = (state == LOAD) && load_we &&  load_addr[AW-1];

    always_ff @(posedge clk) begin
        if (!rst && load_ok) mem[load_addr[LW-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            load_err   <= 1'b0;
        end else begin
            if (load_ok && (word_count != AW'(DEPTH))) word_count <= word_count + 1'b1;
            if (load_bad) load_err <= 1'b1;
        end
    end

    assign accept       = (state == RUN) && fetch_req;
    assign idx          = fetch_addr[ADDR_W-1:2];
    assign misaligned   = |fetch_addr[1:0];
    assign out_of_range = (idx >> LW) != '0;
    assign unloaded     = {1'b0, idx[LW-1:0]} >= word_count;
    assign fault_n      = misaligned || out_of_range;

    // Plain registered read with no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) rd_q <= mem[idx[LW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            nop_q       <= 1'b1;
        end else begin
            fetch_valid <= accept;
            if (accept) begin
                fetch_fault <= fault_n;
                nop_q       <= fault_n || unloaded;
            end
        end
    end

    assign fetch_data = nop_q ? NOP_WORD : rd_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an array-based model.
module tb_instr_mem_ctrl;

    localparam int          DATA_W   = 24;
    localparam int          DEPTH    = 16;
    localparam int          ADDR_W   = 24;
    localparam int          AW       = $clog2(DEPTH) + 1;
    localparam logic [23:0] NOP_WORD = 24'hE00000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_we = 1'b0;
    logic [AW-1:0]     load_addr = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_done = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic              ready;
    logic              load_err;
    logic [AW-1:0]     word_count;

    instr_mem_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP_WORD)
    ) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
        .ready(ready), .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: words tracked in an array, outputs derived from the rules directly.
    logic [DATA_W-1:0] m_mem   [DEPTH];
    bit                m_known [DEPTH];
    bit                model_ok = 0;
    bit                m_run, m_valid, m_fault, m_err, m_data_known;
    int                m_count;
    logic [DATA_W-1:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_valid = 0; m_fault = 0; m_err = 0; m_count = 0;
            m_data = NOP_WORD; m_data_known = 1; model_ok = 1;
        end else if (model_ok) begin
            if (!m_run) begin
                m_valid = 0;
                if (load_we) begin
                    if (int'(load_addr) < DEPTH) begin
                        m_mem[int'(load_addr)]   = load_data;
                        m_known[int'(load_addr)] = 1;
                        if (m_count < DEPTH) m_count++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (load_done) m_run = 1;
            end else if (fetch_req) begin
                int word;
                word = int'(fetch_addr) / 4;
                m_valid = 1;
                if ((int'(fetch_addr) % 4) != 0 || word >= DEPTH) begin
                    m_data = NOP_WORD; m_fault = 1; m_data_known = 1;
                end else if (word >= m_count) begin
                    m_data = NOP_WORD; m_fault = 0; m_data_known = 1;
                end else begin
                    m_data = m_mem[word]; m_fault = 0; m_data_known = m_known[word];
                end
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_ok) begin
            check_value("ready", 32'(ready), 32'(m_run));
            check_value("fetch_valid", 32'(fetch_valid), 32'(m_valid));
            check_value("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            check_value("load_err", 32'(load_err), 32'(m_err));
            check_value("word_count", 32'(word_count), 32'(m_count));
            if (m_data_known) check_value("fetch_data", 32'(fetch_data), 32'(m_data));
        end
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic load_word(input int addr, input logic [DATA_W-1:0] data, input bit done);
        load_we = 1'b1; load_addr = AW'(addr); load_data = data; load_done = done;
        next_cycle();
        load_we = 1'b0; load_done = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] addr);
        fetch_req = 1'b1; fetch_addr = addr;
        next_cycle();
        fetch_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    logic [DATA_W-1:0] prog [4];

    initial begin
        prog[0] = 24'hE68088; prog[1] = 24'hE68108; prog[2] = 24'hE30810; prog[3] = 24'h46808A;

        next_cycle();
        next_cycle();
        check_value("rst_ready", 32'(ready), 32'd0);
        check_value("rst_count", 32'(word_count), 32'd0);
        check_value("rst_data", 32'(fetch_data), 32'(NOP_WORD));
        check_value("rst_valid", 32'(fetch_valid), 32'd0);
        check_value("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) load_word(i, prog[i], 1'b0);
        load_done = 1'b1;
        next_cycle();
        load_done = 1'b0;
        check_value("lit_ready_after_done", 32'(ready), 32'd1);
        check_value("lit_count4", 32'(word_count), 32'd4);

        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = ADDR_W'(i * 4);
            next_cycle();
            check_value("lit_seq_valid", 32'(fetch_valid), 32'd1);
            check_value("lit_seq_data", 32'(fetch_data), 32'(prog[i]));
            check_value("lit_seq_fault", 32'(fetch_fault), 32'd0);
        end
        fetch_req = 1'b0;
        next_cycle();
        check_value("lit_idle_valid", 32'(fetch_valid), 32'd0);
        check_value("lit_idle_hold", 32'(fetch_data), 32'h46808A);

        fetch(24'h6);
        check_value("lit_misalign_data", 32'(fetch_data), 32'(NOP_WORD));
        check_value("lit_misalign_fault", 32'(fetch_fault), 32'd1);
        fetch(ADDR_W'(DEPTH * 4));
        check_value("lit_oob_data", 32'(fetch_data), 32'(NOP_WORD));
        check_value("lit_oob_fault", 32'(fetch_fault), 32'd1);
        fetch(24'h14);
        check_value("lit_unloaded_data", 32'(fetch_data), 32'(NOP_WORD));
        check_value("lit_unloaded_fault", 32'(fetch_fault), 32'd0);

        do_reset();
        for (int i = 0; i < 5; i++) load_word(i, 24'h100000 + 24'(i), 1'b0);
        load_word(DEPTH, 24'hBADBAD, 1'b0);
        check_value("lit_load_err", 32'(load_err), 32'd1);
        check_value("lit_count_after_bad", 32'(word_count), 32'd5);
        load_word(5, 24'hABCDE5, 1'b1);
        check_value("lit_ready_same_cycle", 32'(ready), 32'd1);
        check_value("lit_count6", 32'(word_count), 32'd6);
        load_word(6, 24'h777777, 1'b0);
        check_value("lit_run_load_ignored", 32'(word_count), 32'd6);
        fetch(24'h0);
        check_value("lit_word0", 32'(fetch_data), 32'h100000);
        fetch(24'h14);
        check_value("lit_word5", 32'(fetch_data), 32'hABCDE5);
        fetch(24'h18);
        check_value("lit_word6_masked", 32'(fetch_data), 32'(NOP_WORD));

        fetch_req = 1'b1; fetch_addr = 24'h4;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; fetch_req = 1'b0;
        check_value("lit_rst_valid", 32'(fetch_valid), 32'd0);
        check_value("lit_rst_ready", 32'(ready), 32'd0);
        check_value("lit_rst_count", 32'(word_count), 32'd0);
        load_word(0, 24'h222220, 1'b0);
        load_word(1, 24'h222221, 1'b1);
        fetch(24'hC);
        check_value("lit_reload_valid", 32'(fetch_valid), 32'd1);
        check_value("lit_reload_data", 32'(fetch_data), 32'(NOP_WORD));
        check_value("lit_reload_fault", 32'(fetch_fault), 32'd0);

        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) load_word(i % DEPTH, 24'h300000 + 24'(i), 1'b0);
        check_value("lit_count_saturated", 32'(word_count), 32'(DEPTH));

        // Random traffic; the per-cycle compare process does the checking here.
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            load_we   = ($urandom_range(0, 2) != 0);
            load_addr = AW'($urandom_range(0, 2 * DEPTH - 1));
            load_data = DATA_W'($urandom());
            load_done = ($urandom_range(0, 15) == 0);
            fetch_req = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       fetch_addr = ADDR_W'($urandom());
                1:       fetch_addr = ADDR_W'($urandom_range(0, DEPTH + 1) * 4 + $urandom_range(1, 3));
                default: fetch_addr = ADDR_W'($urandom_range(0, DEPTH + 1) * 4);
            endcase
            next_cycle();
        end
        rst = 1'b0; load_we = 1'b0; load_done = 1'b0; fetch_req = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
